if_stage_ctrl: RTL and testbench



---
 rtl/if_stage_ctrl.sv | 106 ++++++++++
 tb/tb_if_stage_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/if_stage_ctrl.sv
// Fetch-side control: the PC register, the IF/ID pipeline register and
// saturating performance counters. It honours PC-hold, IF/ID stall and
// branch-flush requests coming back from the ID stage.
module if_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             pc_write_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [31:0]      branch_target_i,
  input  logic [31:0]      instr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      ifid_pc_o,
  output logic [31:0]      ifid_instr_o,
  output logic             ifid_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  logic [31:0]      pc_q, pc_d;
  ifid_t            ifid_q, ifid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             stall_path;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  // Next-state selection: stall path beats flush, flush beats normal fetch.
  always_comb begin
    pc_d        = pc_q;
    ifid_d      = ifid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    instr_cnt_d = instr_cnt_q;
    stall_path  = stall_i | ~pc_write_i;

    if (start_i) begin
      if (stall_path) begin
        // The branch decision in ID is not trustworthy while stalled, so
        // flush_i is not looked at on this path.
        if (pc_write_i) pc_d = pc_q + 32'd4;
        if (!stall_i) begin
          // PC held but IF/ID free: insert a bubble so the held fetch is
          // not delivered twice.
          ifid_d.instr = NOP_INSTR;
          ifid_d.valid = 1'b0;
        end else begin
          stall_cnt_d = sat_inc(stall_cnt_q);
        end
      end else if (flush_i) begin
        pc_d         = {branch_target_i[31:2], 2'b00};
        ifid_d.instr = NOP_INSTR;
        ifid_d.valid = 1'b0;
        flush_cnt_d  = sat_inc(flush_cnt_q);
      end else begin
        pc_d        = pc_q + 32'd4;
        ifid_d      = '{pc: pc_q, instr: instr_i, valid: 1'b1};
        instr_cnt_d = sat_inc(instr_cnt_q);
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_q        <= RESET_PC;
      ifid_q      <= '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      ifid_q      <= ifid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign pc_o         = pc_q;
  assign ifid_pc_o    = ifid_q.pc;
  assign ifid_instr_o = ifid_q.instr;
  assign ifid_valid_o = ifid_q.valid;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
  assign instr_cnt_o  = instr_cnt_q;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed bench for if_stage_ctrl: reset, fetch, stalls, flushes, PC wrap,
// freeze, mid-stall reset and counter saturation on a narrow instance.
module tb_if_stage_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h00A0_0093;
  localparam logic [31:0] I1  = 32'h0020_0113;

  logic        clk = 1'b0;
  logic        rst, start, pc_write, stall, flush;
  logic [31:0] target, instr;

  logic [31:0] pc, ifid_pc, ifid_instr;
  logic        ifid_valid;
  logic [31:0] stall_cnt, flush_cnt, instr_cnt;

  logic [31:0] s_pc, s_ifid_pc, s_ifid_instr;
  logic        s_ifid_valid;
  logic [1:0]  s_stall_cnt, s_flush_cnt, s_instr_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_stage_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pc_write_i(pc_write),
    .stall_i(stall), .flush_i(flush), .branch_target_i(target), .instr_i(instr),
    .pc_o(pc), .ifid_pc_o(ifid_pc), .ifid_instr_o(ifid_instr),
    .ifid_valid_o(ifid_valid), .stall_cnt_o(stall_cnt),
    .flush_cnt_o(flush_cnt), .instr_cnt_o(instr_cnt)
  );

  if_stage_ctrl #(.CNT_W(2)) dut_small (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pc_write_i(pc_write),
    .stall_i(stall), .flush_i(flush), .branch_target_i(target), .instr_i(instr),
    .pc_o(s_pc), .ifid_pc_o(s_ifid_pc), .ifid_instr_o(s_ifid_instr),
    .ifid_valid_o(s_ifid_valid), .stall_cnt_o(s_stall_cnt),
    .flush_cnt_o(s_flush_cnt), .instr_cnt_o(s_instr_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc,
                         input logic [31:0] e_ipc, input logic [31:0] e_ins,
                         input logic e_v, input logic [31:0] e_sc,
                         input logic [31:0] e_fc, input logic [31:0] e_ic);
    chk({tag, ".pc"},    pc,                 e_pc);
    chk({tag, ".ifpc"},  ifid_pc,            e_ipc);
    chk({tag, ".ifins"}, ifid_instr,         e_ins);
    chk({tag, ".vld"},   {31'b0, ifid_valid}, {31'b0, e_v});
    chk({tag, ".scnt"},  stall_cnt,          e_sc);
    chk({tag, ".fcnt"},  flush_cnt,          e_fc);
    chk({tag, ".icnt"},  instr_cnt,          e_ic);
  endtask

  initial begin
    rst = 1'b0; start = 1'b1; pc_write = 1'b1; stall = 1'b0; flush = 1'b0;
    target = 32'h0; instr = I0;
    #1;
    step(); step();
    chk_all("reset", 32'h0, 32'h0, NOP, 1'b0, 0, 0, 0);

    // Normal fetch.
    rst = 1'b1;
    step(); chk_all("run1", 32'h4, 32'h0, I0, 1'b1, 0, 0, 1);
    step(); chk_all("run2", 32'h8, 32'h4, I0, 1'b1, 0, 0, 2);

    // Load-use stall at pc=8.
    pc_write = 1'b0; stall = 1'b1;
    step(); chk_all("luse", 32'h8, 32'h4, I0, 1'b1, 1, 0, 2);
    pc_write = 1'b1; stall = 1'b0; instr = I1;
    step(); chk_all("resume", 32'hC, 32'h8, I1, 1'b1, 1, 0, 3);
    step(); chk_all("run3", 32'h10, 32'hC, I1, 1'b1, 1, 0, 4);

    // Branch flush at pc=16.
    flush = 1'b1; target = 32'h40;
    step(); chk_all("flush", 32'h40, 32'hC, NOP, 1'b0, 1, 1, 4);
    flush = 1'b0;
    step(); chk_all("post_fl", 32'h44, 32'h40, I1, 1'b1, 1, 1, 5);

    // Stall and flush together: flush ignored.
    stall = 1'b1; pc_write = 1'b0; flush = 1'b1; target = 32'h80;
    step(); chk_all("st_fl", 32'h44, 32'h40, I1, 1'b1, 2, 1, 5);

    // PC held, IF/ID free: bubble.
    stall = 1'b0;
    step(); chk_all("bubble", 32'h44, 32'h40, NOP, 1'b0, 2, 1, 5);

    // IF/ID held, PC advances: fetch dropped.
    stall = 1'b1; pc_write = 1'b1; flush = 1'b0;
    step(); chk_all("drop", 32'h48, 32'h40, NOP, 1'b0, 3, 1, 5);
    stall = 1'b0;
    step(); chk_all("run4", 32'h4C, 32'h48, I1, 1'b1, 3, 1, 6);

    // PC wrap via flush to 0xFFFF_FFFE (low bits cleared).
    flush = 1'b1; target = 32'hFFFF_FFFE;
    step(); chk_all("fl_top", 32'hFFFF_FFFC, 32'h48, NOP, 1'b0, 3, 2, 6);
    flush = 1'b0;
    step(); chk_all("wrap", 32'h0, 32'hFFFF_FFFC, I1, 1'b1, 3, 2, 7);

    // Freeze: start low, noisy inputs, nothing moves.
    start = 1'b0; stall = 1'b1; flush = 1'b1; pc_write = 1'b0; target = 32'h100;
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("freeze", 32'h0, 32'hFFFF_FFFC, I1, 1'b1, 3, 2, 7);
    end

    // Reset during a stall.
    start = 1'b1; flush = 1'b0; rst = 1'b0;
    step(); chk_all("rst_st", 32'h0, 32'h0, NOP, 1'b0, 0, 0, 0);
    chk("s_rst.scnt", {30'b0, s_stall_cnt}, 32'd0);

    // Five stall cycles: narrow counter saturates at 3.
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("sat.small", {30'b0, s_stall_cnt}, 32'd3);
    chk("sat.wide",  stall_cnt,            32'd5);
    chk("sat.pc",    pc,                   32'h0);

    // First fetch after reset is at RESET_PC.
    stall = 1'b0; pc_write = 1'b1;
    step(); chk_all("rel", 32'h4, 32'h0, I1, 1'b1, 5, 0, 1);
    chk("s_rel.icnt", {30'b0, s_instr_cnt}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
